// File: rtl/tanh_pkg.sv
// Shared types and constants for the tanh piecewise-linear sequencer.
// Holds the sequencer state enum, FP unit opcode, segment breakpoints and FP32 1.0.
// Breakpoints are FP32 magnitudes (sign stripped) compared as unsigned integers.
package tanh_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_MUL_REQ  = 3'd2,
        S_MUL_WAIT = 3'd3,
        S_ADD_REQ  = 3'd4,
        S_ADD_WAIT = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    typedef enum logic {
        FPU_MUL = 1'b0,
        FPU_ADD = 1'b1
    } fpu_op_e;

    // For positive IEEE-754 values the bit pattern orders like the value,
    // so a 31-bit unsigned compare of the magnitude is a valid |x| compare.
    localparam logic [30:0] BP_0P75 = 31'h3F40_0000;
    localparam logic [30:0] BP_1P5  = 31'h3FC0_0000;
    localparam logic [30:0] BP_2P75 = 31'h4030_0000;
    localparam logic [30:0] BP_5P0  = 31'h40A0_0000;

    localparam logic [31:0] FP32_ONE = 32'h3F80_0000;

endpackage

// File: rtl/tanh_pwl_sequencer_if.sv
// Handshake/bus bundle for tanh_pwl_sequencer: upstream x, downstream y, params ROM, shared FPU.
// master = the sequencer; slave = its environment (accumulator, cell update, ROM, FP unit).
// Ports: in_* valid/ready, out_* valid/ready, rom_index/slope/intercept, fpu_req_*/fpu_op/fpu_a/fpu_b, fpu_rsp_*.
interface tanh_pwl_sequencer_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;

    logic [2:0]  rom_index;
    logic [31:0] rom_slope;
    logic [31:0] rom_intercept;

    logic        fpu_req_valid;
    logic        fpu_req_ready;
    logic        fpu_op;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_rsp_valid;
    logic [31:0] fpu_rsp_data;

    modport master (
        input  in_valid, in_x, out_ready, rom_slope, rom_intercept,
               fpu_req_ready, fpu_rsp_valid, fpu_rsp_data,
        output in_ready, out_valid, out_y, rom_index,
               fpu_req_valid, fpu_op, fpu_a, fpu_b
    );

    modport slave (
        output in_valid, in_x, out_ready, rom_slope, rom_intercept,
               fpu_req_ready, fpu_rsp_valid, fpu_rsp_data,
        input  in_ready, out_valid, out_y, rom_index,
               fpu_req_valid, fpu_op, fpu_a, fpu_b
    );

endinterface

// File: rtl/tanh_segment_select.sv
// Purpose: map an FP32 magnitude to one of five tanh segments (0..4).
// Latency: combinational, zero cycles.
// Backpressure: none (pure function). Ports: mag[30:0] in, index[2:0] out.
module tanh_segment_select
    import tanh_pkg::*;
(
    input  logic [30:0] mag,
    output logic [2:0]  index
);

    // Strict less-than so a value exactly on a breakpoint takes the higher
    // segment; Inf/NaN magnitudes exceed every breakpoint and land in 4.
    always_comb begin
        if (mag < BP_0P75)      index = 3'd0;
        else if (mag < BP_1P5)  index = 3'd1;
        else if (mag < BP_2P75) index = 3'd2;
        else if (mag < BP_5P0)  index = 3'd3;
        else                    index = 3'd4;
    end

endmodule

// File: rtl/tanh_pwl_sequencer.sv
// Purpose: tanh(x) via 5-segment PWL: ROM lookup, slope*|x| + intercept on shared FPU, sign restored.
// Latency: out_valid 5 clocks after input handshake (FPU ready, 1-cycle rsp); 1 clock on saturation bypass.
// Backpressure: in_ready only in IDLE; FPU requests held stable until fpu_req_ready; out_y held until out_ready.
// Ports: clk, reset (async active-high), bus (tanh_pwl_sequencer_if.master).
// Option: TANH_SATURATE_BYPASS_EN skips the FPU for segment 4 and returns +/-1.0 directly.
module tanh_pwl_sequencer
    import tanh_pkg::*;
#(
    parameter int FLOAT_WIDTH = 32
)(
    input  logic                 clk,
    input  logic                 reset,
    tanh_pwl_sequencer_if.master bus
);

    state_e                 state_q, state_d;
    logic [30:0]            mag_q, mag_d;
    logic                   sign_q, sign_d;
    logic [2:0]             idx_q, idx_d;
    logic [FLOAT_WIDTH-1:0] slope_q, slope_d;
    logic [FLOAT_WIDTH-1:0] icpt_q, icpt_d;
    logic [FLOAT_WIDTH-1:0] prod_q, prod_d;
    logic [FLOAT_WIDTH-1:0] y_q, y_d;

    logic [2:0]             seg_idx;
    logic                   in_ready;
    logic                   out_valid;
    logic                   req_valid;
    fpu_op_e                req_op;
    logic [FLOAT_WIDTH-1:0] req_a;
    logic [FLOAT_WIDTH-1:0] req_b;

    tanh_segment_select u_seg (
        .mag   (bus.in_x[30:0]),
        .index (seg_idx)
    );

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        sign_d    = sign_q;
        idx_d     = idx_q;
        slope_d   = slope_q;
        icpt_d    = icpt_q;
        prod_d    = prod_q;
        y_d       = y_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        req_valid = 1'b0;
        req_op    = FPU_MUL;
        req_a     = '0;
        req_b     = '0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    mag_d   = bus.in_x[30:0];
                    sign_d  = bus.in_x[31];
                    // Index is registered here so rom_index is already
                    // settled for the whole LOOKUP cycle.
                    idx_d   = seg_idx;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                slope_d = bus.rom_slope;
                icpt_d  = bus.rom_intercept;
                state_d = S_MUL_REQ;
`ifdef TANH_SATURATE_BYPASS_EN
                if (idx_q == 3'd4) begin
                    y_d     = {sign_q, FP32_ONE[30:0]};
                    state_d = S_DONE;
                end
`endif
            end
            S_MUL_REQ: begin
                req_valid = 1'b1;
                req_op    = FPU_MUL;
                req_a     = slope_q;
                req_b     = {1'b0, mag_q};
                if (bus.fpu_req_ready) state_d = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (bus.fpu_rsp_valid) begin
                    prod_d  = bus.fpu_rsp_data;
                    state_d = S_ADD_REQ;
                end
            end
            S_ADD_REQ: begin
                req_valid = 1'b1;
                req_op    = FPU_ADD;
                req_a     = prod_q;
                req_b     = icpt_q;
                if (bus.fpu_req_ready) state_d = S_ADD_WAIT;
            end
            S_ADD_WAIT: begin
                if (bus.fpu_rsp_valid) begin
                    // tanh is odd: evaluate on |x|, then reapply the input sign.
                    y_d     = {sign_q, bus.fpu_rsp_data[30:0]};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            idx_q   <= '0;
            slope_q <= '0;
            icpt_q  <= '0;
            prod_q  <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            idx_q   <= idx_d;
            slope_q <= slope_d;
            icpt_q  <= icpt_d;
            prod_q  <= prod_d;
            y_q     <= y_d;
        end
    end

    // Operands come straight from registers that only change outside the
    // request states, so they stay stable while a request is stalled.
    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_y         = y_q;
    assign bus.rom_index     = idx_q;
    assign bus.fpu_req_valid = req_valid;
    assign bus.fpu_op        = req_op;
    assign bus.fpu_a         = req_a;
    assign bus.fpu_b         = req_b;

endmodule

// File: tb/tb_tanh_pwl_sequencer.sv
module tb_tanh_pwl_sequencer;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    tanh_pwl_sequencer_if bus();

    tanh_pwl_sequencer #(.FLOAT_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parameter ROM model (combinational), hand-chosen per-segment values.
    always_comb begin
        case (bus.rom_index)
            3'd0:    begin bus.rom_slope = 32'h3F58CC2A; bus.rom_intercept = 32'h00000000; end
            3'd1:    begin bus.rom_slope = 32'h3EB851EC; bus.rom_intercept = 32'h3EBAF4E5; end
            3'd2:    begin bus.rom_slope = 32'h3DCCCCCD; bus.rom_intercept = 32'h3F4CCCCD; end
            3'd3:    begin bus.rom_slope = 32'h3C23D70A; bus.rom_intercept = 32'h3F7AE148; end
            default: begin bus.rom_slope = 32'h00000000; bus.rom_intercept = 32'h3F800000; end
        endcase
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // Runs one transaction; a scripted FPU returns mul_rsp then add_rsp, one
    // cycle after each accept. Reports observed values back to the caller.
    task automatic do_txn(
        input  logic [31:0] x,
        input  logic [31:0] mul_rsp,
        input  logic [31:0] add_rsp,
        input  int          req_stall,
        input  int          out_stall,
        output logic [2:0]  idx,
        output logic [31:0] ma,
        output logic [31:0] mb,
        output logic [31:0] aa,
        output logic [31:0] ab,
        output logic [31:0] y,
        output int          lat,
        output int          nreq,
        output int          unstable,
        output bit          timeout
    );
        int          cyc;
        int          rs;
        int          os;
        bit          pend;
        bit          seen;
        bit          holding;
        bit          done;
        logic [31:0] pend_dat;
        logic [31:0] ha;
        logic [31:0] hb;
        logic        hop;
        idx = 3'h7; ma = 'x; mb = 'x; aa = 'x; ab = 'x; y = 'x;
        lat = -1; nreq = 0; unstable = 0; timeout = 0;
        rs = req_stall; os = out_stall;
        pend = 0; seen = 0; holding = 0; done = 0;
        pend_dat = '0; ha = '0; hb = '0; hop = 1'b0;

        @(negedge clk);
        bus.in_x = x;
        bus.in_valid = 1'b1;
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        idx = bus.rom_index;
        cyc = 0;
        while (!done && cyc < 200) begin
            bus.fpu_rsp_valid = pend;
            bus.fpu_rsp_data  = pend ? pend_dat : 32'h0;
            pend = 0;
            bus.fpu_req_ready = 1'b0;
            if (bus.fpu_req_valid) begin
                if (holding && (bus.fpu_a !== ha || bus.fpu_b !== hb || bus.fpu_op !== hop))
                    unstable++;
                ha = bus.fpu_a; hb = bus.fpu_b; hop = bus.fpu_op; holding = 1;
                if (rs > 0) begin
                    rs--;
                end else begin
                    bus.fpu_req_ready = 1'b1;
                    holding = 0;
                    nreq++;
                    pend = 1;
                    if (bus.fpu_op == 1'b0) begin
                        ma = bus.fpu_a; mb = bus.fpu_b; pend_dat = mul_rsp;
                    end else begin
                        aa = bus.fpu_a; ab = bus.fpu_b; pend_dat = add_rsp;
                    end
                end
            end
            bus.out_ready = 1'b0;
            if (bus.out_valid) begin
                if (!seen) begin
                    seen = 1; lat = cyc; y = bus.out_y;
                end else if (bus.out_y !== y) begin
                    unstable++;
                end
                if (bus.in_ready !== 1'b0) unstable++;
                if (os > 0) os--;
                else begin
                    bus.out_ready = 1'b1;
                    done = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.fpu_req_ready = 1'b0;
        bus.fpu_rsp_valid = 1'b0;
        timeout = !done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.fpu_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", bus.fpu_req_valid); end
        checks++; if (bus.out_y !== 32'h0) begin errors++; $display("FAIL rst_out_y: got %h want 0", bus.out_y); end
        checks++; if (bus.fpu_a !== 32'h0 || bus.fpu_b !== 32'h0) begin errors++; $display("FAIL rst_fpu_ab: got %h %h want 0 0", bus.fpu_a, bus.fpu_b); end
        checks++; if (bus.rom_index !== 3'd0 || bus.fpu_op !== 1'b0) begin errors++; $display("FAIL rst_idx_op: got %0d %b want 0 0", bus.rom_index, bus.fpu_op); end
        reset = 1'b0;
        bus.fpu_rsp_valid = 1'b1;
        bus.fpu_rsp_data  = 32'hDEADBEEF;
        @(negedge clk);
        bus.fpu_rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.fpu_req_valid !== 1'b0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL rst_stray_rsp: got rdy=%b req=%b ov=%b want 1 0 0", bus.in_ready, bus.fpu_req_valid, bus.out_valid); end
    endtask

    task automatic test_half();
        logic [2:0] idx; logic [31:0] ma, mb, aa, ab, y; int lat, nreq, unst; bit to;
        do_txn(32'h3F000000, 32'h3ED8CC2A, 32'h3ED8CC2A, 0, 0, idx, ma, mb, aa, ab, y, lat, nreq, unst, to);
        checks++; if (to) begin errors++; $display("FAIL half_timeout: got timeout want out_valid"); end
        checks++; if (idx !== 3'd0) begin errors++; $display("FAIL half_idx: got %0d want 0", idx); end
        checks++; if (ma !== 32'h3F58CC2A || mb !== 32'h3F000000) begin errors++; $display("FAIL half_mul_ops: got %h %h want 3f58cc2a 3f000000", ma, mb); end
        checks++; if (aa !== 32'h3ED8CC2A || ab !== 32'h0) begin errors++; $display("FAIL half_add_ops: got %h %h want 3ed8cc2a 0", aa, ab); end
        checks++; if (y !== 32'h3ED8CC2A) begin errors++; $display("FAIL half_y: got %h want 3ed8cc2a", y); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL half_latency: got %0d want 5", lat); end
    endtask

    task automatic test_neg_one();
        logic [2:0] idx; logic [31:0] ma, mb, aa, ab, y; int lat, nreq, unst; bit to;
        do_txn(32'hBF800000, 32'h3EB851EC, 32'h3F39A027, 0, 0, idx, ma, mb, aa, ab, y, lat, nreq, unst, to);
        checks++; if (idx !== 3'd1) begin errors++; $display("FAIL neg1_idx: got %0d want 1", idx); end
        checks++; if (mb !== 32'h3F800000) begin errors++; $display("FAIL neg1_mul_b: got %h want 3f800000", mb); end
        checks++; if (aa !== 32'h3EB851EC || ab !== 32'h3EBAF4E5) begin errors++; $display("FAIL neg1_add_ops: got %h %h want 3eb851ec 3ebaf4e5", aa, ab); end
        checks++; if (y !== 32'hBF39A027) begin errors++; $display("FAIL neg1_y: got %h want bf39a027", y); end
    endtask

    task automatic test_breakpoints();
        logic [31:0] xs [7];
        logic [2:0]  ei [7];
        logic [2:0] idx; logic [31:0] ma, mb, aa, ab, y; int lat, nreq, unst; bit to;
        xs = '{32'h3F3FFFFF, 32'h3F400000, 32'h3FBFFFFF, 32'h3FC00000, 32'h40300000, 32'h40A00000, 32'h7FC00000};
        ei = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        for (int i = 0; i < 7; i++) begin
            do_txn(xs[i], 32'h0, 32'h3F000000, 0, 0, idx, ma, mb, aa, ab, y, lat, nreq, unst, to);
            checks++; if (idx !== ei[i]) begin errors++; $display("FAIL bp_idx[%h]: got %0d want %0d", xs[i], idx, ei[i]); end
        end
    endtask

    task automatic test_neg_inf();
        logic [2:0] idx; logic [31:0] ma, mb, aa, ab, y; int lat, nreq, unst; bit to;
        do_txn(32'hFF800000, 32'h00000000, 32'h3F800000, 0, 0, idx, ma, mb, aa, ab, y, lat, nreq, unst, to);
        checks++; if (idx !== 3'd4) begin errors++; $display("FAIL ninf_idx: got %0d want 4", idx); end
        checks++; if (y !== 32'hBF800000) begin errors++; $display("FAIL ninf_y: got %h want bf800000", y); end
`ifdef TANH_SATURATE_BYPASS_EN
        checks++; if (nreq !== 0) begin errors++; $display("FAIL ninf_nreq: got %0d want 0", nreq); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL ninf_latency: got %0d want 1", lat); end
`else
        checks++; if (nreq !== 2) begin errors++; $display("FAIL ninf_nreq: got %0d want 2", nreq); end
        checks++; if (ma !== 32'h0 || mb !== 32'h7F800000 || ab !== 32'h3F800000)
            begin errors++; $display("FAIL ninf_ops: got %h %h %h want 0 7f800000 3f800000", ma, mb, ab); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL ninf_latency: got %0d want 5", lat); end
`endif
    endtask

    task automatic test_neg_zero();
        logic [2:0] idx; logic [31:0] ma, mb, aa, ab, y; int lat, nreq, unst; bit to;
        do_txn(32'h80000000, 32'h00000000, 32'h00000000, 0, 0, idx, ma, mb, aa, ab, y, lat, nreq, unst, to);
        checks++; if (idx !== 3'd0 || mb !== 32'h0) begin errors++; $display("FAIL nzero_idx_b: got %0d %h want 0 0", idx, mb); end
        checks++; if (y !== 32'h80000000) begin errors++; $display("FAIL nzero_y: got %h want 80000000", y); end
    endtask

    task automatic test_backpressure();
        logic [2:0] idx; logic [31:0] ma, mb, aa, ab, y; int lat, nreq, unst; bit to;
        do_txn(32'h3F000000, 32'h3ED8CC2A, 32'h3ED8CC2A, 0, 10, idx, ma, mb, aa, ab, y, lat, nreq, unst, to);
        checks++; if (unst !== 0 || to) begin errors++; $display("FAIL bp_out_hold: got %0d unstable cycles want 0", unst); end
        checks++; if (y !== 32'h3ED8CC2A) begin errors++; $display("FAIL bp_out_y: got %h want 3ed8cc2a", y); end
        do_txn(32'hBF800000, 32'h3EB851EC, 32'h3F39A027, 5, 0, idx, ma, mb, aa, ab, y, lat, nreq, unst, to);
        checks++; if (unst !== 0) begin errors++; $display("FAIL bp_req_hold: got %0d unstable cycles want 0", unst); end
        checks++; if (ma !== 32'h3EB851EC || mb !== 32'h3F800000) begin errors++; $display("FAIL bp_req_ops: got %h %h want 3eb851ec 3f800000", ma, mb); end
        checks++; if (lat !== 10) begin errors++; $display("FAIL bp_req_latency: got %0d want 10", lat); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] idx; logic [31:0] ma, mb, aa, ab, y; int lat, nreq, unst; bit to;
        @(negedge clk);
        bus.in_x = 32'h3F000000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.fpu_req_valid !== 1'b1) begin errors++; $display("FAIL rmid_reach_mul: got %b want 1", bus.fpu_req_valid); end
        bus.fpu_req_ready = 1'b1;
        @(negedge clk);
        bus.fpu_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.fpu_req_valid !== 1'b0)
            begin errors++; $display("FAIL rmid_async: got rdy=%b ov=%b req=%b want 1 0 0", bus.in_ready, bus.out_valid, bus.fpu_req_valid); end
        checks++; if (bus.out_y !== 32'h0 || bus.rom_index !== 3'd0)
            begin errors++; $display("FAIL rmid_values: got y=%h idx=%0d want 0 0", bus.out_y, bus.rom_index); end
        @(negedge clk);
        reset = 1'b0;
        bus.fpu_rsp_valid = 1'b1;
        bus.fpu_rsp_data  = 32'h12345678;
        @(negedge clk);
        bus.fpu_rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.fpu_req_valid !== 1'b0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL rmid_stray: got rdy=%b req=%b ov=%b want 1 0 0", bus.in_ready, bus.fpu_req_valid, bus.out_valid); end
        do_txn(32'h3F000000, 32'h3ED8CC2A, 32'h3ED8CC2A, 0, 0, idx, ma, mb, aa, ab, y, lat, nreq, unst, to);
        checks++; if (y !== 32'h3ED8CC2A || lat !== 5) begin errors++; $display("FAIL rmid_after: got y=%h lat=%0d want 3ed8cc2a 5", y, lat); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_x = 32'h0;
        bus.out_ready = 1'b0;
        bus.fpu_req_ready = 1'b0;
        bus.fpu_rsp_valid = 1'b0;
        bus.fpu_rsp_data = 32'h0;

        test_reset();
        test_half();
        test_neg_one();
        test_breakpoints();
        test_neg_inf();
        test_neg_zero();
        test_backpressure();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
